des_expand_mix: RTL and testbench
=================================

// Module: des_expand_mix
// PURPOSE
//  DES f-function front stage: expands the 32-bit right half R to 48 bits (E table), XORs it with
//  the round subkey and registers the result. The eight 6-bit slices feed SBox1..SBox8 directly.
//  Valid/ready handshake, 1-cycle latency, full throughput via a 1-entry skid buffer.
//  Tracks the round tag and flags out-of-order round sequences.
// PARAMETERS
//  CHECK_SEQ  1  1 = enable round-sequence checker; 0 = seq_err tied 0
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   reset, synchronous, active-high
//  flush      in   1   sync clear of pipeline contents (not of seq_err)
//  in_valid   in   1   r_in/subkey/round_in valid
//  in_ready   out  1   stage can accept
//  r_in       in   32  right half R, DES bit 1 = r_in[31]
//  subkey     in   48  round key K, DES bit 1 = subkey[47]
//  round_in   in   4   round index 0..15
//  out_valid  out  1   mix_out valid
//  out_ready  in   1   downstream (S-box/P stage) accepts
//  mix_out    out  48  E(R)^K; [47:42]->S1 ... [17:12]->S6 ... [5:0]->S8
//  round_out  out  4   round tag of mix_out
//  last_out   out  1   round_out==15
//  seq_err    out  1   sticky: accepted round_in != expected
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, mix_out=0, round_out=0, last_out=0, seq_err=0,
//    skid empty, expected round=0; in_ready=1 from the first cycle after reset.
//  - E table (DES numbering, output bit i takes R bit E[i]): 32 1 2 3 4 5 4 5 6 7 8 9 8 9 10 11
//    12 13 12 13 14 15 16 17 16 17 18 19 20 21 20 21 22 23 24 25 24 25 26 27 28 29 28 29 30 31 32 1.
//    DES bit n maps to vector index width-n. Pure wiring + XOR, no arithmetic.
//  - Accept when in_valid && in_ready; result visible on mix_out the next cycle (latency 1).
//  - Output reg updates when !out_valid || out_ready. If an accept occurs while out_valid && !out_ready,
//    data goes to the skid entry; in_ready=0 next cycle (in_ready = !skid_full, registered).
//  - When output drains (out_ready) and skid full: skid moves to output, skid empties, in_ready=1.
//  - out_valid && !out_ready: mix_out/round_out/last_out held stable (no change until handshake).
//  - Simultaneous accept + drain with skid empty: new data straight to output, out_valid stays 1.
//  - last_out registered alongside round_out, never combinational from round_in.
//  - Sequence check: expected starts at 0; on accept, if round_in != expected, seq_err<=1 (sticky
//    until rst); expected <= round_in+1 mod 16 (15 wraps to 0, resyncs after error).
//  - flush: out_valid=0, skid empty, in_ready=1 next cycle, expected<=0; an input presented in the
//    flush cycle is dropped (in_valid ignored). rst has priority over flush.
//  - Reset mid-transfer: all held data discarded, no partial output, no out_valid glitch.
// STRUCTURE
//  - Package des_pkg: E table constant (48 x 6-bit indices), DES_HALF_W=32, DES_KEY_W=48,
//    SBOX_IN_W=6, SBOX_OUT_W=4, NUM_SBOX=8, ROUND_W=4; shared with S-box and P stages.
//  - One sub-module: des_expand (combinational 32->48 E permutation), reused by decrypt path.
//  - Top: des_expand + XOR + output reg + skid reg + sequence checker.
// TESTING
//  1. R=32'h0000_0000, K=0, round 0 -> mix_out=48'h0000_0000_0000, round_out=0, 1 cycle later.
//  2. R=32'h8000_0001, K=0 -> mix_out=48'hC000_0000_0003 (wrap bits 32/1 at both ends).
//  3. R=32'hF0AA_F0AA, K=48'h1B02_EFFC_7072 -> mix_out=48'h6117_BA86_6527; slice [17:12]=6'b100110,
//     SBox6 out=4'd5.
//  4. Backpressure: out_ready=0 for 3 cycles over rounds 0,1,2 -> round 1 in skid, in_ready=0, round 2
//     stalls; release -> outputs 0,1,2 in order, none lost or duplicated, out data stable while stalled.
//  5. Rounds 0..15 back-to-back, out_ready=1 -> 16 outputs at 1/cycle, last_out only on 15, seq_err=0;
//     then round 3 -> seq_err=1 and stays 1 through a subsequent correct sequence.
//  6. rst (or flush) with output and skid full -> next cycle out_valid=0, in_ready=1;
//     flush leaves seq_err unchanged, rst clears it.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants and types for the f-function stages (expansion, S-box, P).
// The E table lists, for each output bit 1..48, the source R bit (DES numbering).
package des_pkg;
  localparam int DES_HALF_W = 32;
  localparam int DES_KEY_W  = 48;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int NUM_SBOX   = 8;
  localparam int ROUND_W    = 4;

  localparam logic [5:0] E_TABLE [DES_KEY_W] = '{
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
    6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
  };

  typedef struct packed {
    logic [DES_KEY_W-1:0] mix;
    logic [ROUND_W-1:0]   round;
    logic                 last;
  } mix_word_t;
endpackage

// File: rtl/des_expand_mix_if.sv
// Stream bundle for the expansion/key-mix stage: input handshake, output handshake, status.
interface des_expand_mix_if;
  import des_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DES_HALF_W-1:0] r_in;
  logic [DES_KEY_W-1:0]  subkey;
  logic [ROUND_W-1:0]    round_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DES_KEY_W-1:0]  mix_out;
  logic [ROUND_W-1:0]    round_out;
  logic                  last_out;
  logic                  seq_err;

  modport slave (
    input  in_valid, r_in, subkey, round_in, out_ready,
    output in_ready, out_valid, mix_out, round_out, last_out, seq_err
  );

  modport master (
    output in_valid, r_in, subkey, round_in, out_ready,
    input  in_ready, out_valid, mix_out, round_out, last_out, seq_err
  );
endinterface

// File: rtl/des_expand.sv
// DES E expansion: 32-bit R half to 48 bits, pure wiring.
// DES bit n lives at vector index (width - n) on both sides.
module des_expand
  import des_pkg::*;
(
  input  logic [DES_HALF_W-1:0] i_r,
  output logic [DES_KEY_W-1:0]  o_e
);
  genvar g;
  generate
    for (g = 0; g < DES_KEY_W; g++) begin : g_e
      localparam int SRC = DES_HALF_W - int'(E_TABLE[g]);
      assign o_e[DES_KEY_W-1-g] = i_r[SRC];
    end
  endgenerate
endmodule

// File: rtl/des_expand_mix.sv
// DES f-function front stage: E(R) xor K, one registered output plus a one-entry skid
// buffer for full throughput, and a sticky checker for out-of-order round tags.
module des_expand_mix
  import des_pkg::*;
#(
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  des_expand_mix_if.slave  bus
);
  logic [DES_KEY_W-1:0] w_e;
  logic                 w_acc;
  logic                 w_out_en;
  mix_word_t            w_new;

  mix_word_t            r_out;
  logic                 r_out_valid;
  mix_word_t            r_skid;
  logic                 r_skid_valid;
  logic                 r_in_ready;
  logic [ROUND_W-1:0]   r_exp;
  logic                 r_seq_err;

  des_expand u_expand (
    .i_r (bus.r_in),
    .o_e (w_e)
  );

  assign w_new.mix   = w_e ^ bus.subkey;
  assign w_new.round = bus.round_in;
  assign w_new.last  = (bus.round_in == 4'd15);

  // Inputs presented during a flush cycle are dropped, never accepted.
  assign w_acc    = bus.in_valid & r_in_ready & ~flush;
  assign w_out_en = ~r_out_valid | bus.out_ready;

  // Output register and skid entry; in_ready tracks skid occupancy one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_en) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_acc) begin
        r_out        <= w_new;
        r_out_valid  <= 1'b1;
        r_in_ready   <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_acc) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end else begin
      r_in_ready   <= ~r_skid_valid;
    end
  end

  // Round-sequence checker: expected tag resyncs to round_in+1 on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp     <= 4'd0;
      r_seq_err <= 1'b0;
    end else if (flush) begin
      r_exp     <= 4'd0;
    end else if (w_acc) begin
      if (CHECK_SEQ && (bus.round_in != r_exp)) begin
        r_seq_err <= 1'b1;
      end
      r_exp <= bus.round_in + 4'd1;
    end else begin
      r_exp <= r_exp;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.mix_out   = r_out.mix;
  assign bus.round_out = r_out.round;
  assign bus.last_out  = r_out.last;
  assign bus.seq_err   = CHECK_SEQ ? r_seq_err : 1'b0;
endmodule

// File: tb/tb_des_expand_mix.sv
// Scoreboard bench for des_expand_mix: directed vectors push expected words, a monitor
// compares the queue head on every cycle the output is valid (held data must match too).
module tb_des_expand_mix;
  import des_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  mix_word_t sb[$];

  des_expand_mix_if bus();

  des_expand_mix #(.CHECK_SEQ(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] r, input logic [47:0] k, input logic [3:0] rnd,
                      input logic [47:0] exp);
    bit acc = 1'b0;
    mix_word_t w;
    bus.in_valid = 1'b1;
    bus.r_in     = r;
    bus.subkey   = k;
    bus.round_in = rnd;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc     = 1'b1;
        w.mix   = exp;
        w.round = rnd;
        w.last  = (rnd == 4'd15);
        sb.push_back(w);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout round=%0d", rnd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Monitor: every valid output cycle is compared against the queue head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%h expected=none", bus.mix_out);
        end else begin
          chk("mix_out",   64'(bus.mix_out),   64'(sb[0].mix));
          chk("round_out", 64'(bus.round_out), 64'(sb[0].round));
          chk("last_out",  64'(bus.last_out),  64'(sb[0].last));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int t0;
    logic [47:0] k;
    bus.in_valid  = 1'b0;
    bus.r_in      = 32'd0;
    bus.subkey    = 48'd0;
    bus.round_in  = 4'd0;
    bus.out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_mix_out",   64'(bus.mix_out),   64'd0);
    chk("rst_round_out", 64'(bus.round_out), 64'd0);
    chk("rst_seq_err",   64'(bus.seq_err),   64'd0);
    @(posedge clk); #1;

    // Directed E/xor vectors.
    send(32'h0000_0000, 48'h0, 4'd0, 48'h0000_0000_0000);
    send(32'h8000_0001, 48'h0, 4'd1, 48'hC000_0000_0003);
    send(32'hF0AA_F0AA, 48'h1B02_EFFC_7072, 4'd2, 48'h6117_BA86_6527);
    idle(3);
    chk("seq_ok_0_2", 64'(bus.seq_err), 64'd0);
    chk("sb_empty_1", 64'(sb.size()), 64'd0);

    // Backpressure: round 1 lands in the skid, round 2 stalls until release.
    pulse_flush();
    bus.out_ready = 1'b0;
    send(32'h0000_0000, 48'h1111_2222_3333, 4'd0, 48'h1111_2222_3333);
    send(32'hFFFF_FFFF, 48'h0F0F_0F0F_0F0F, 4'd1, 48'hF0F0_F0F0_F0F0);
    @(negedge clk);
    chk("skid_full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    fork
      send(32'h0000_0000, 48'hABCD_EF01_2345, 4'd2, 48'hABCD_EF01_2345);
      begin
        idle(3);
        bus.out_ready = 1'b1;
      end
    join
    idle(3);
    chk("sb_empty_bp", 64'(sb.size()), 64'd0);
    chk("seq_ok_bp",   64'(bus.seq_err), 64'd0);

    // Rounds 0..15 back-to-back at full rate.
    pulse_flush();
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      k = {12{i[3:0]}};
      send(32'h0000_0000, k, i[3:0], k);
    end
    chk("throughput_cycles", 64'(cyc - t0), 64'd16);
    idle(2);
    chk("seq_ok_16", 64'(bus.seq_err), 64'd0);
    chk("sb_empty_16", 64'(sb.size()), 64'd0);

    // Out-of-order round, then a correct continuation: error must stick.
    send(32'h0000_0000, 48'h3333_3333_3333, 4'd3, 48'h3333_3333_3333);
    idle(1);
    chk("seq_err_set", 64'(bus.seq_err), 64'd1);
    for (int i = 4; i < 8; i++) begin
      k = {12{i[3:0]}};
      send(32'hFFFF_FFFF, k, i[3:0], ~k);
    end
    idle(2);
    chk("seq_err_sticky", 64'(bus.seq_err), 64'd1);

    // Flush with output and skid full; the input offered in the flush cycle is dropped.
    bus.out_ready = 1'b0;
    send(32'h0000_0000, 48'h8888_8888_8888, 4'd8, 48'h8888_8888_8888);
    send(32'h0000_0000, 48'h9999_9999_9999, 4'd9, 48'h9999_9999_9999);
    bus.in_valid = 1'b1;
    bus.subkey   = 48'hDEAD_BEEF_0000;
    bus.round_in = 4'd10;
    pulse_flush();
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
    chk("flush_seq_err",   64'(bus.seq_err),   64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle(3);

    // Reset with output and skid full.
    bus.out_ready = 1'b0;
    send(32'h0000_0000, 48'h0000_0000_0001, 4'd0, 48'h0000_0000_0001);
    send(32'h0000_0000, 48'h0000_0000_0002, 4'd1, 48'h0000_0000_0002);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rstm_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstm_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rstm_mix_out",   64'(bus.mix_out),   64'd0);
    chk("rstm_last_out",  64'(bus.last_out),  64'd0);
    chk("rstm_seq_err",   64'(bus.seq_err),   64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h8000_0001, 48'h0, 4'd0, 48'hC000_0000_0003);
    idle(3);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    chk("seq_ok_end",   64'(bus.seq_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
